vga_timing_gen: RTL and testbench

// - 640x480@60Hz VGA raster timing generator (25.175 MHz pixel clock, one pixel per clk).
// - Provides pixel counters, a display-active flag and sync pulses.
// - Feeds the pixel/colour pipeline and the per-line/per-frame event logic of the top-level video/audio design.

---
 rtl/vga_timing_gen.sv | 78 +++++++
 tb/tb_vga_timing_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz raster timing generator, one pixel per clk.
// Free-running column/line counters and registered active-low sync pulses.
// The syncs lag the counters by one clock. display_on is combinational from
// the counters, so a consumer that registers its colour output once lines
// up with the registered syncs.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  // Derived raster landmarks, held at counter width.
  localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  // Next-state: column always advances, line advances only at end of line,
  // both wrap in a single step. Syncs decode the current (not next) position.
  always_comb begin
    hpos_d  = hpos_q + 10'd1;
    vpos_d  = vpos_q;
    if (hpos_q == H_MAX) begin
      hpos_d = 10'd0;
      if (vpos_q == V_MAX) begin
        vpos_d = 10'd0;
      end else begin
        vpos_d = vpos_q + 10'd1;
      end
    end
    hsync_d = ~((hpos_q >= HS_START) && (hpos_q <= HS_END));
    vsync_d = ~((vpos_q >= VS_START) && (vpos_q <= VS_END));
  end

  // State registers; reset parks the raster at (0,0) with both syncs idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q  <= 10'd0;
      vpos_q  <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for the VGA timing generator.
// Two instances share clock and reset: one with the real 640x480 timing and
// one with a shortened vertical raster (13 lines) so that several whole
// frames, vsync pulses and frame wraps fit in a short run.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // full-size instance
  logic       hs_f, vs_f, de_f;
  logic [9:0] hp_f, vp_f;
  // short-frame instance: V_MAX=12, VS_START=8, VS_END=9, visible lines 0..5
  logic       hs_s, vs_s, de_s;
  logic [9:0] hp_s, vp_s;

  localparam int S_VT   = 13;
  localparam int S_VDIS = 6;
  localparam int S_VSS  = 8;
  localparam int S_VSE  = 9;
  localparam int S_FRAME = 800 * S_VT;

  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .hsync(hs_f), .vsync(vs_f),
    .display_on(de_f), .hpos(hp_f), .vpos(vp_f)
  );

  vga_timing_gen #(
    .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .hsync(hs_s), .vsync(vs_s),
    .display_on(de_s), .hpos(hp_s), .vpos(vp_s)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Expected {hpos,vpos,hsync,vsync,display_on} k clocks after reset release.
  function automatic logic [22:0] exp_vec(int k, int vt, int vdis, int vss, int vse);
    int h, v, hp, vp;
    logic hs, vs, de;
    h  = k % 800;
    v  = (k / 800) % vt;
    de = (h < 640) && (v < vdis);
    if (k == 0) begin
      hs = 1'b1;
      vs = 1'b1;
    end else begin
      hp = (k - 1) % 800;
      vp = ((k - 1) / 800) % vt;
      hs = !((hp >= 656) && (hp <= 751));
      vs = !((vp >= vss) && (vp <= vse));
    end
    return {10'(h), 10'(v), hs, vs, de};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (hp_f !== 10'd0) begin failures++; $display("FAIL reset_hpos got=%0d exp=0", hp_f); end
    checks++; if (vp_f !== 10'd0) begin failures++; $display("FAIL reset_vpos got=%0d exp=0", vp_f); end
    checks++; if (hs_f !== 1'b1)  begin failures++; $display("FAIL reset_hsync got=%b exp=1", hs_f); end
    checks++; if (vs_f !== 1'b1)  begin failures++; $display("FAIL reset_vsync got=%b exp=1", vs_f); end
    checks++; if (de_f !== 1'b1)  begin failures++; $display("FAIL reset_display_on got=%b exp=1", de_f); end
    checks++; if ({hp_s, vp_s, hs_s, vs_s, de_s} !== {10'd0, 10'd0, 3'b111})
      begin failures++; $display("FAIL reset_short got=%h exp=%h", {hp_s, vp_s, hs_s, vs_s, de_s}, {10'd0, 10'd0, 3'b111}); end
    rst_n = 1'b1;
  endtask

  task automatic test_line();
    int bad = 0, hs_low = 0, first_low = -1, last_low = -1, de_off = 0, h799 = -1;
    logic [22:0] obs, exp;
    apply_reset();
    for (int k = 1; k <= 800; k++) begin
      tick();
      obs = {hp_f, vp_f, hs_f, vs_f, de_f};
      exp = exp_vec(k, 525, 480, 490, 491);
      if (obs !== exp) begin
        if (bad == 0) $display("line trace first difference k=%0d got=%h exp=%h", k, obs, exp);
        bad++;
      end
      if (hs_f === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = k;
        last_low = k;
      end
      if (vp_f == 10'd0 && hp_f >= 10'd640 && de_f === 1'b0) de_off++;
      if (k == 799) h799 = int'(hp_f);
    end
    checks++; if (bad !== 0)        begin failures++; $display("FAIL line_trace bad_cycles=%0d exp=0", bad); end
    checks++; if (h799 !== 799)     begin failures++; $display("FAIL line_hpos_max got=%0d exp=799", h799); end
    checks++; if ({hp_f, vp_f} !== {10'd0, 10'd1})
      begin failures++; $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", hp_f, vp_f); end
    checks++; if (hs_low !== 96)    begin failures++; $display("FAIL hsync_low_len got=%0d exp=96", hs_low); end
    checks++; if (first_low !== 657) begin failures++; $display("FAIL hsync_first_low got=%0d exp=657", first_low); end
    checks++; if (last_low !== 752) begin failures++; $display("FAIL hsync_last_low got=%0d exp=752", last_low); end
    checks++; if (de_off !== 160)   begin failures++; $display("FAIL display_off_cols got=%0d exp=160", de_off); end
  endtask

  task automatic test_frame();
    int bad = 0, wraps = 0, max_h = 0, max_v = 0;
    int hs_falls = 0, hs_bad_per = 0, last_hs_fall = -1;
    int vs_falls = 0, vs_low = 0;
    int vs_fall_at[3];
    logic prev_hs, prev_vs;
    logic [9:0] prev_h, prev_v;
    logic [22:0] obs, exp;
    apply_reset();
    prev_hs = 1'b1; prev_vs = 1'b1; prev_h = 10'd0; prev_v = 10'd0;
    for (int k = 1; k <= 3 * S_FRAME; k++) begin
      tick();
      obs = {hp_s, vp_s, hs_s, vs_s, de_s};
      exp = exp_vec(k, S_VT, S_VDIS, S_VSS, S_VSE);
      if (obs !== exp) begin
        if (bad == 0) $display("frame trace first difference k=%0d got=%h exp=%h", k, obs, exp);
        bad++;
      end
      if (int'(hp_s) > max_h) max_h = int'(hp_s);
      if (int'(vp_s) > max_v) max_v = int'(vp_s);
      if (prev_h == 10'd799 && prev_v == 10'(S_VT - 1) && hp_s == 10'd0 && vp_s == 10'd0) wraps++;
      if (prev_hs === 1'b1 && hs_s === 1'b0) begin
        if (last_hs_fall >= 0 && (k - last_hs_fall) != 800) hs_bad_per++;
        last_hs_fall = k;
        hs_falls++;
      end
      if (prev_vs === 1'b1 && vs_s === 1'b0) begin
        if (vs_falls < 3) vs_fall_at[vs_falls] = k;
        vs_falls++;
      end
      if (vs_s === 1'b0) vs_low++;
      prev_hs = hs_s; prev_vs = vs_s; prev_h = hp_s; prev_v = vp_s;
    end
    checks++; if (bad !== 0)       begin failures++; $display("FAIL frame_trace bad_cycles=%0d exp=0", bad); end
    checks++; if ({hp_s, vp_s} !== 20'd0)
      begin failures++; $display("FAIL frame_end_pos got=(%0d,%0d) exp=(0,0)", hp_s, vp_s); end
    checks++; if (wraps !== 3)     begin failures++; $display("FAIL frame_wraps got=%0d exp=3", wraps); end
    checks++; if (max_h !== 799)   begin failures++; $display("FAIL hpos_max got=%0d exp=799", max_h); end
    checks++; if (max_v !== S_VT - 1) begin failures++; $display("FAIL vpos_max got=%0d exp=%0d", max_v, S_VT - 1); end
    checks++; if (hs_falls !== 39) begin failures++; $display("FAIL hsync_falls got=%0d exp=39", hs_falls); end
    checks++; if (hs_bad_per !== 0) begin failures++; $display("FAIL hsync_period bad=%0d exp=0", hs_bad_per); end
    checks++; if (vs_falls !== 3)  begin failures++; $display("FAIL vsync_falls got=%0d exp=3", vs_falls); end
    checks++; if (vs_low !== 4800) begin failures++; $display("FAIL vsync_low_len got=%0d exp=4800", vs_low); end
    if (vs_falls >= 3) begin
      checks++; if (vs_fall_at[0] !== S_VSS * 800 + 1)
        begin failures++; $display("FAIL vsync_first_fall got=%0d exp=%0d", vs_fall_at[0], S_VSS * 800 + 1); end
      checks++; if (vs_fall_at[1] - vs_fall_at[0] !== S_FRAME)
        begin failures++; $display("FAIL vsync_period1 got=%0d exp=%0d", vs_fall_at[1] - vs_fall_at[0], S_FRAME); end
      checks++; if (vs_fall_at[2] - vs_fall_at[1] !== S_FRAME)
        begin failures++; $display("FAIL vsync_period2 got=%0d exp=%0d", vs_fall_at[2] - vs_fall_at[1], S_FRAME); end
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    logic [22:0] obs, exp;
    apply_reset();
    repeat (S_VSE * 800 + 700) tick();
    // Inside both sync pulses at (700, VS_END).
    checks++; if ({hp_s, vp_s, hs_s, vs_s} !== {10'd700, 10'(S_VSE), 2'b00})
      begin failures++; $display("FAIL midreset_setup got=(%0d,%0d,%b,%b) exp=(700,%0d,0,0)", hp_s, vp_s, hs_s, vs_s, S_VSE); end
    checks++; if (hs_f !== 1'b0) begin failures++; $display("FAIL midreset_setup_full_hsync got=%b exp=0", hs_f); end
    rst_n = 1'b0;
    tick();
    checks++; if ({hp_s, vp_s, hs_s, vs_s} !== {20'd0, 2'b11})
      begin failures++; $display("FAIL midreset_short got=(%0d,%0d,%b,%b) exp=(0,0,1,1)", hp_s, vp_s, hs_s, vs_s); end
    checks++; if ({hp_f, vp_f, hs_f, vs_f} !== {20'd0, 2'b11})
      begin failures++; $display("FAIL midreset_full got=(%0d,%0d,%b,%b) exp=(0,0,1,1)", hp_f, vp_f, hs_f, vs_f); end
    rst_n = 1'b1;
    // No partial pulse: the raster restarts cleanly from (0,0).
    for (int k = 1; k <= 1700; k++) begin
      tick();
      obs = {hp_s, vp_s, hs_s, vs_s, de_s};
      exp = exp_vec(k, S_VT, S_VDIS, S_VSS, S_VSE);
      if (obs !== exp) begin
        if (bad == 0) $display("post-reset trace first difference k=%0d got=%h exp=%h", k, obs, exp);
        bad++;
      end
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL midreset_restart bad_cycles=%0d exp=0", bad); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
